// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage.
// An input register captures the execute-stage slot, a two-state FSM talks to
// DMEM with a req/ack handshake, and an output register feeds write-back.
// Upstream stages are frozen through out_stall while DMEM has not acknowledged.
// Optional feature macro: MEM_ACCESS_STORE_FWD_EN. It adds a one-entry
// last-store record that serves matching loads without a DMEM access.
module mem_access #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int REG_IDX_WIDTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic                       in_flush,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [DMEM_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] dmem_wdata,
    input  logic                       dmem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] dmem_rdata,
    output logic                       out_stall,
    output logic                       out_act_write_res_to_reg,
    output logic [DMEM_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PC_WIDTH-1:0]        out_pc
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t r_state, w_state_next;

    logic                       r_load, r_store, r_wb, r_flush;
    logic [DMEM_ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
    logic [DMEM_WORD_WIDTH-1:0] r_wr_word, r_res;
    logic [PC_WIDTH-1:0]        r_pc;
    logic [REG_IDX_WIDTH-1:0]   r_idx;

    logic                       r_out_wb;
    logic [DMEM_WORD_WIDTH-1:0] r_out_res;
    logic [REG_IDX_WIDTH-1:0]   r_out_idx;
    logic [PC_WIDTH-1:0]        r_out_pc;

    logic                       w_load_only;
    logic                       w_fwd_hit;
    logic [DMEM_WORD_WIDTH-1:0] w_fwd_data;
    logic                       w_access;
    logic                       w_done;

    // Input register: follows the execute stage unless this stage is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load    <= 1'b0;
            r_store   <= 1'b0;
            r_wb      <= 1'b0;
            r_flush   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_word <= '0;
            r_pc      <= '0;
            r_res     <= '0;
            r_idx     <= '0;
        end else if (!out_stall) begin
            r_load    <= in_act_load_dmem;
            r_store   <= in_act_store_dmem;
            r_wb      <= in_act_write_res_to_reg;
            r_flush   <= in_flush;
            r_rd_addr <= in_dmem_rd_addr;
            r_wr_addr <= in_dmem_wr_addr;
            r_wr_word <= in_dmem_wr_word;
            r_pc      <= in_pc;
            r_res     <= in_res;
            r_idx     <= in_res_reg_idx;
        end
    end

    // A store wins when both load and store are flagged.
    assign w_load_only = r_load & ~r_store;

`ifdef MEM_ACCESS_STORE_FWD_EN
    logic                       r_fwd_valid;
    logic [DMEM_ADDR_WIDTH-1:0] r_fwd_addr;
    logic [DMEM_WORD_WIDTH-1:0] r_fwd_data;

    assign w_fwd_hit  = ~r_flush & w_load_only & r_fwd_valid & (r_fwd_addr == r_rd_addr);
    assign w_fwd_data = r_fwd_data;

    // Last-store record: captured when a store is acknowledged by DMEM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else if (w_done && r_store) begin
            r_fwd_valid <= 1'b1;
            r_fwd_addr  <= r_wr_addr;
            r_fwd_data  <= r_wr_word;
        end
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    // A slot needs DMEM when it is live, touches memory and is not forwarded.
    assign w_access = ~r_flush & (r_load | r_store) & ~w_fwd_hit;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state and DMEM handshake; request fields come straight from the
    // held input register, so they stay stable for the whole wait.
    always_comb begin
        w_state_next = r_state;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        out_stall    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    dmem_req   = 1'b1;
                    dmem_we    = r_store;
                    dmem_addr  = r_store ? r_wr_addr : r_rd_addr;
                    dmem_wdata = r_store ? r_wr_word : '0;
                    if (dmem_ack) begin
                        w_done = 1'b1;
                    end else begin
                        out_stall    = 1'b1;
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = r_store;
                dmem_addr  = r_store ? r_wr_addr : r_rd_addr;
                dmem_wdata = r_store ? r_wr_word : '0;
                if (dmem_ack) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    out_stall = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output register: write enable drops while stalled so every instruction
    // writes back once; flushed slots retire as all-zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_wb  <= 1'b0;
            r_out_res <= '0;
            r_out_idx <= '0;
            r_out_pc  <= '0;
        end else if (out_stall) begin
            r_out_wb <= 1'b0;
        end else if (r_flush) begin
            r_out_wb  <= 1'b0;
            r_out_res <= '0;
            r_out_idx <= '0;
            r_out_pc  <= '0;
        end else begin
            r_out_wb  <= r_wb;
            r_out_idx <= r_idx;
            r_out_pc  <= r_pc;
            if (w_load_only) r_out_res <= w_fwd_hit ? w_fwd_data : dmem_rdata;
            else             r_out_res <= r_res;
        end
    end

    assign out_act_write_res_to_reg = r_out_wb;
    assign out_res                  = r_out_res;
    assign out_res_reg_idx          = r_out_idx;
    assign out_pc                   = r_out_pc;

endmodule
